// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: masks level-sensitive sources, presents one
// IRQ plus vector, and serializes service via an acknowledge / end-of-interrupt handshake.
module irq_ctrl #(
    parameter int unsigned      ABITS = 32,
    parameter int unsigned      DBITS = 32,
    parameter logic [ABITS-1:0] RBASE = ABITS'(32'hF000_0100),
    parameter int unsigned      NSRC  = 4
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             LOCK,
    input  logic [ABITS-1:0] ABUS,
    inout  wire  [DBITS-1:0] RBUS,
    input  logic             RE,
    input  logic [DBITS-1:0] WBUS,
    input  logic             WE,
    input  logic [NSRC-1:0]  SRC,
    input  logic             IACK,
    output logic             IRQ,
    output logic [2:0]       IVEC
);

    localparam logic [ABITS-1:0] A_IPEND = RBASE;
    localparam logic [ABITS-1:0] A_IMASK = RBASE + ABITS'(4);
    localparam logic [ABITS-1:0] A_ICTL  = RBASE + ABITS'(8);
    localparam logic [ABITS-1:0] A_IID   = RBASE + ABITS'(12);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [NSRC-1:0] ssrc_q, ssrc_d;
    logic [NSRC-1:0] imask_q, imask_d;
    logic            gie_q, gie_d;
    logic [2:0]      cur_q, cur_d;

    logic [NSRC-1:0] ipend;
    logic [2:0]      iid;
    logic            wr_mask, wr_ctl, eoi;
    logic [DBITS-1:0] rdata;
    logic            rd_hit;
    logic            unused_wbus;

    assign unused_wbus = ^WBUS;

    // Pending set and lowest-index (highest-priority) encoder
    always_comb begin
        ipend = ssrc_q & imask_q;
        iid   = 3'd0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (ipend[i]) begin
                iid = 3'(i);
            end
        end
    end

    assign wr_mask = WE && (ABUS == A_IMASK);
    assign wr_ctl  = WE && (ABUS == A_ICTL);
    assign eoi     = wr_ctl && !WBUS[1];

    // Next-state and outputs
    always_comb begin
        state_d = state_q;
        ssrc_d  = SRC;
        imask_d = imask_q;
        gie_d   = gie_q;
        cur_d   = cur_q;
        IRQ     = 1'b0;
        IVEC    = 3'd0;

        if (wr_mask) begin
            imask_d = WBUS[NSRC-1:0];
        end
        if (wr_ctl) begin
            gie_d = WBUS[0];
        end

        case (state_q)
            S_IDLE: begin
                if (gie_q && (ipend != '0)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                IRQ  = 1'b1;
                IVEC = iid;
                // Acknowledge beats a same-cycle withdraw
                if (IACK) begin
                    state_d = S_SVC;
                    cur_d   = iid;
                end else if ((ipend == '0) || !gie_q) begin
                    state_d = S_IDLE;
                end
            end
            S_SVC: begin
                IVEC = cur_q;
                if (eoi) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; LOCK=0 freezes everything, reset included
    always_ff @(posedge CLK) begin
        if (LOCK) begin
            if (INIT) begin
                state_q <= S_IDLE;
                ssrc_q  <= '0;
                imask_q <= '0;
                gie_q   <= 1'b0;
                cur_q   <= 3'd0;
            end else begin
                state_q <= state_d;
                ssrc_q  <= ssrc_d;
                imask_q <= imask_d;
                gie_q   <= gie_d;
                cur_q   <= cur_d;
            end
        end
    end

    // Read decode; bus is released unless a register is selected
    always_comb begin
        rdata  = '0;
        rd_hit = 1'b1;
        case (ABUS)
            A_IPEND: rdata[NSRC-1:0] = ipend;
            A_IMASK: rdata[NSRC-1:0] = imask_q;
            A_ICTL: begin
                rdata[0]   = gie_q;
                rdata[1]   = (state_q == S_SVC);
                rdata[6:4] = cur_q;
            end
            A_IID:   rdata[2:0] = iid;
            default: rd_hit = 1'b0;
        endcase
    end

    assign RBUS = (RE && rd_hit) ? rdata : {DBITS{1'bz}};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: expectations are queued as stimulus is applied
// and compared when the register read or IRQ/IVEC outputs are sampled.
module tb_irq_ctrl;

    localparam logic [31:0] RBASE = 32'hF000_0100;
    localparam logic [31:0] O_IPEND = 32'h0;
    localparam logic [31:0] O_IMASK = 32'h4;
    localparam logic [31:0] O_ICTL  = 32'h8;
    localparam logic [31:0] O_IID   = 32'hC;

    logic        clk = 1'b0;
    logic        init, lock, re, we, iack;
    logic [31:0] abus, wbus;
    logic [3:0]  src;
    wire  [31:0] rbus;
    logic        irq;
    logic [2:0]  ivec;

    typedef struct {
        string       tag;
        logic [31:0] val;
        logic [31:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    irq_ctrl #(
        .ABITS(32),
        .DBITS(32),
        .RBASE(RBASE),
        .NSRC (4)
    ) dut (
        .CLK (clk),
        .INIT(init),
        .LOCK(lock),
        .ABUS(abus),
        .RBUS(rbus),
        .RE  (re),
        .WBUS(wbus),
        .WE  (we),
        .SRC (src),
        .IACK(iack),
        .IRQ (irq),
        .IVEC(ivec)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val, input logic [31:0] mask);
        exp_t e;
        e.tag  = tag;
        e.val  = val;
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: got %h expected nothing queued", obs);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs & e.mask, e.val & e.mask);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        abus = RBASE + off;
        wbus = data;
        we   = 1'b1;
        cyc(1);
        we   = 1'b0;
        abus = 32'h0;
        wbus = 32'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp,
                      input logic [31:0] mask);
        sb_push(tag, exp, mask);
        abus = RBASE + off;
        re   = 1'b1;
        #1;
        sb_pop_chk(rbus);
        re   = 1'b0;
        abus = 32'h0;
    endtask

    task automatic out(input string tag, input logic irq_e, input logic [2:0] ivec_e);
        sb_push(tag, {28'h0, irq_e, ivec_e}, 32'hF);
        #1;
        sb_pop_chk({28'h0, irq, ivec});
    endtask

    task automatic ack();
        iack = 1'b1;
        cyc(1);
        iack = 1'b0;
    endtask

    initial begin
        logic z_ok;
        init = 1'b1;
        lock = 1'b1;
        re   = 1'b0;
        we   = 1'b0;
        iack = 1'b0;
        abus = 32'h0;
        wbus = 32'h0;
        src  = 4'h0;
        cyc(2);
        init = 1'b0;

        // Reset / idle
        rd("rst_ictl", O_ICTL, 32'h0, '1);
        rd("rst_imask", O_IMASK, 32'h0, '1);
        rd("rst_ipend", O_IPEND, 32'h0, '1);
        rd("rst_iid", O_IID, 32'h0, '1);
        out("rst_out", 1'b0, 3'd0);
        abus = RBASE + 32'h10;
        re   = 1'b1;
        #1;
        z_ok = (rbus === 32'hzzzz_zzzz) || (rbus === 32'h0);
        chk("unmapped_rbus_z", {31'h0, z_ok}, 32'h1);
        re   = 1'b0;
        abus = 32'h0;
        wr(O_IPEND, 32'hF);
        rd("ipend_ro", O_IPEND, 32'h0, '1);

        // Basic service on source 2
        wr(O_IMASK, 32'h4);
        wr(O_ICTL, 32'h1);
        src = 4'b0100;
        cyc(1);
        out("basic_k", 1'b0, 3'd0);
        rd("basic_ipend", O_IPEND, 32'h4, '1);
        cyc(1);
        out("basic_req", 1'b1, 3'd2);
        rd("basic_iid", O_IID, 32'h2, '1);
        // Acknowledge together with a GIE=0 write
        abus = RBASE + O_ICTL;
        wbus = 32'h0;
        we   = 1'b1;
        iack = 1'b1;
        cyc(1);
        we   = 1'b0;
        iack = 1'b0;
        abus = 32'h0;
        out("basic_svc", 1'b0, 3'd2);
        rd("basic_ictl", O_ICTL, 32'h22, '1);
        ack();
        rd("svc_iack_ignored", O_ICTL, 32'h22, '1);
        src = 4'b0000;
        wr(O_ICTL, 32'h1);
        out("basic_eoi", 1'b0, 3'd0);
        cyc(2);
        out("basic_idle", 1'b0, 3'd0);

        // Priority
        wr(O_IMASK, 32'hF);
        src = 4'b1000;
        cyc(2);
        out("prio_src3", 1'b1, 3'd3);
        src = 4'b1010;
        cyc(1);
        out("prio_src1", 1'b1, 3'd1);
        ack();
        out("prio_svc", 1'b0, 3'd1);
        rd("prio_ictl", O_ICTL, 32'h13, '1);
        src = 4'b1000;
        wr(O_ICTL, 32'h1);
        out("prio_eoi", 1'b0, 3'd0);
        cyc(1);
        out("prio_rereq", 1'b1, 3'd3);
        ack();
        src = 4'b0000;
        wr(O_ICTL, 32'h1);
        cyc(2);
        out("prio_clean", 1'b0, 3'd0);

        // Masking withdraws the request
        src = 4'b0001;
        cyc(2);
        out("mask_req", 1'b1, 3'd0);
        wr(O_IMASK, 32'h0);
        out("mask_wr_edge", 1'b1, 3'd0);
        cyc(1);
        out("mask_withdrawn", 1'b0, 3'd0);
        ack();
        rd("mask_insvc", O_ICTL, 32'h0, 32'h2);
        out("mask_after_ack", 1'b0, 3'd0);

        // IACK in the cycle IPEND drops to 0
        wr(O_IMASK, 32'hF);
        src = 4'b0100;
        cyc(2);
        out("drop_req", 1'b1, 3'd2);
        src = 4'b0000;
        cyc(1);
        out("drop_ipend0", 1'b1, 3'd0);
        ack();
        rd("drop_ictl", O_ICTL, 32'h03, '1);

        // EOI and IACK in the same cycle
        abus = RBASE + O_ICTL;
        wbus = 32'h1;
        we   = 1'b1;
        iack = 1'b1;
        cyc(1);
        we   = 1'b0;
        iack = 1'b0;
        abus = 32'h0;
        rd("eoi_iack_insvc", O_ICTL, 32'h0, 32'h2);
        cyc(2);
        out("eoi_iack_idle", 1'b0, 3'd0);

        // INIT mid-service
        src = 4'b0010;
        cyc(2);
        out("init_req", 1'b1, 3'd1);
        ack();
        rd("init_svc", O_ICTL, 32'h13, '1);
        init = 1'b1;
        cyc(1);
        init = 1'b0;
        rd("init_ictl", O_ICTL, 32'h0, '1);
        rd("init_imask", O_IMASK, 32'h0, '1);
        out("init_out", 1'b0, 3'd0);
        cyc(2);
        out("init_stays_idle", 1'b0, 3'd0);

        // LOCK freezes registers
        src = 4'b0000;
        wr(O_IMASK, 32'hF);
        wr(O_ICTL, 32'h1);
        cyc(1);
        lock = 1'b0;
        wr(O_IMASK, 32'h0);
        rd("lock_imask", O_IMASK, 32'hF, '1);
        src = 4'b0001;
        cyc(3);
        out("lock_no_irq", 1'b0, 3'd0);
        rd("lock_ipend", O_IPEND, 32'h0, '1);
        lock = 1'b1;
        cyc(2);
        out("unlock_req", 1'b1, 3'd0);
        lock = 1'b0;
        init = 1'b1;
        cyc(1);
        init = 1'b0;
        out("lock_init_held", 1'b1, 3'd0);
        rd("lock_init_imask", O_IMASK, 32'hF, '1);
        lock = 1'b1;
        src  = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller on the processor's I/O bus, downstream of the Timer, KeyDev and SwDev devices. It consumes their level-sensitive INTR outputs, applies per-source and global masks, and presents one IRQ line plus a vector ID to the processor. A three-state acknowledge/end-of-interrupt handshake serializes interrupt service. No nesting.

## Interface
- ABITS, 32, ABUS width.
- DBITS, 32, data bus width.
- RBASE, 32'hF0000100, base address of the four registers, at RBASE+0/+4/+8/+C.
- NSRC, 4, number of interrupt sources, 1..8.

- CLK  in  1  single clock; all state changes on posedge CLK.
- INIT  in  1  synchronous, active-high reset; takes effect on the posedge CLK where INIT=1.
- LOCK  in  1  clock-valid enable; when 0, all registers hold, INIT included.
- ABUS  in  ABITS  bus address.
- RBUS  inout  DBITS  read data; driven only during a selected read, else Z.
- RE  in  1  read enable.
- WBUS  in  DBITS  write data.
- WE  in  1  write enable.
- SRC  in  NSRC  interrupt inputs, level-sensitive, active-high; index 0 has highest priority.
- IACK  in  1  processor acknowledge, one-cycle pulse.
- IRQ  out  1  interrupt request to the processor.
- IVEC  out  3  source ID.

## Operation
- Register decode uses an exact ABUS match. Every unused bit reads 0. Reads have no side effects.
  - IPEND (+0, RO): bits[NSRC-1:0] = SSRC & IMASK, where SSRC is SRC registered once. Writes are ignored.
  - IMASK (+4, RW): bits[NSRC-1:0]; 1 = source enabled.
  - ICTL (+8):
    - bit0 GIE: RW.
    - bit1 INSVC: reads 1 in SVC. Writing 0 to bit1 is EOI; writing 1 is ignored.
    - bits[6:4] CUR: RO.
  - IID (+C, RO): bits[2:0] = priority-encoded lowest set index of IPEND. Reads 0 when IPEND=0.
- FSM states: IDLE, REQ, SVC.
  - IDLE -> REQ when GIE=1 and IPEND!=0.
  - REQ -> IDLE when IPEND=0 or GIE=0. This withdraws the request, no service.
  - REQ -> SVC on IACK=1: CUR <= IID.
  - SVC -> IDLE on an EOI write.
  - IACK in IDLE or SVC is ignored.
- Outputs are combinational from registered state:
  - IRQ = (state==REQ).
  - IVEC = IID in REQ, CUR in SVC, 0 in IDLE.
- Sources are not cleared by this block; software clears the device Rdy before EOI. A source still pending at EOI re-requests.
- Reset values: SSRC=0, IMASK=0, GIE=0, CUR=0, state=IDLE, IRQ=0, IVEC=0, RBUS=Z.

## Timing
- Request latency is 2 edges:
  - SRC high before edge k -> SSRC set at edge k.
  - state REQ at edge k+1 -> IRQ visible after edge k+1.
- Mask or GIE writes take effect at the edge they are written. The FSM sees the new value from the next cycle.
- Priority changes in REQ: if a higher-priority source becomes pending, IVEC/IID follow it combinationally. CUR latches the value present at the IACK edge.
- Simultaneous events:
  - IACK and IPEND dropping to 0 in the same cycle (REQ): IACK wins -> SVC, CUR = IID of that cycle (0 if none).
  - EOI write and IACK in the same cycle (SVC): EOI wins -> IDLE; IACK is ignored.
  - GIE write to 0 and IACK in the same cycle (REQ): -> SVC, and GIE is 0 afterwards.
  - INIT with anything: INIT wins, all registers reset.
- INIT mid-SVC: state returns to IDLE and CUR is cleared. No EOI is needed.
- LOCK=0: state and registers are frozen. RBUS reads still respond combinationally.

## Test plan
- Reset/idle: INIT 1 cycle; read ICTL, IMASK, IPEND -> 0, 0, 0; IRQ=0, IVEC=0. A read at RBASE+10 leaves RBUS=Z.
- Basic service (NSRC=4):
  - Stimulus: IMASK=4'b0100, GIE=1, raise SRC[2] before edge k.
  - Request: IRQ=1 after edge k+1, IVEC=2.
  - Acknowledge: IACK pulse -> IRQ=0, ICTL reads 0x00000022.
  - EOI: drop SRC, write ICTL=0x1 -> IDLE, IRQ stays 0.
- Priority: IMASK=0xF, GIE=1.
  - SRC=4'b1000 -> IVEC=3 in REQ.
  - Then SRC=4'b1010 -> IVEC=1.
  - IACK -> CUR=1.
  - EOI with SRC[3] still high -> IRQ reasserts 2 edges later with IVEC=3.
- Masking/withdraw: in REQ with SRC[0], write IMASK=0 -> state IDLE and IRQ=0 two cycles after the write; a subsequent IACK leaves ICTL.INSVC=0.
- Simultaneity: in SVC, assert an EOI write and IACK in the same cycle -> IDLE; with SRC=0, IRQ stays 0.
- Reset and LOCK:
  - INIT asserted mid-SVC -> IDLE, CUR=0, GIE=0 next cycle.
  - With LOCK=0, an IMASK write is not stored and SRC changes do not alter IRQ.
